// File: rtl/aes_key_sched_ctrl.sv
// Round-robin sharing of one AES-128 key-expansion unit between two requesters:
// grants one, latches its key, strobes the load, then walks the ten expansion rounds.
module aes_key_sched_ctrl #(
    parameter int NRND = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    output logic [1:0]   gnt,
    output logic         kld,
    output logic [127:0] key_out,
    output logic         rk_vld,
    output logic [3:0]   rk_idx,
    output logic [1:0]   done,
    output logic         busy
);

    // One-hot so every strobe below is a single flop bit (or a flop AND a stable flop).
    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_LOAD   = 4'b0010;
    localparam logic [3:0] S_EXPAND = 4'b0100;
    localparam logic [3:0] S_DONE   = 4'b1000;

    localparam logic [3:0] LAST_IDX = 4'(NRND);

    logic [3:0]   state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         last_q, last_d;
    logic         win;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = req[1];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        key_d   = key_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d = S_LOAD;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    key_d   = win ? key1 : key0;
                    last_d  = win;
                    idx_d   = 4'd0;
                end
            end
            S_LOAD: begin
                state_d = S_EXPAND;
                idx_d   = 4'd1;
            end
            S_EXPAND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            key_q   <= '0;
            idx_q   <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign key_out = key_q;
    assign rk_idx  = idx_q;
    assign kld     = state_q[1];
    assign rk_vld  = state_q[2];
    assign busy    = ~state_q[0];
    assign done    = gnt_q & {2{state_q[3]}};

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: stimulus predicts grants/keys/load cycles,
// a monitor checks every cycle of each sequence plus an rcon model driven by kld.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req = 2'b00;
    logic [127:0] key0 = '0;
    logic [127:0] key1 = '0;
    logic [1:0]   gnt;
    logic         kld;
    logic [127:0] key_out;
    logic         rk_vld;
    logic [3:0]   rk_idx;
    logic [1:0]   done;
    logic         busy;

    aes_key_sched_ctrl #(.NRND(10)) dut (
        .clk(clk), .rst(rst), .req(req), .key0(key0), .key1(key1),
        .gnt(gnt), .kld(kld), .key_out(key_out), .rk_vld(rk_vld),
        .rk_idx(rk_idx), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]   g;
        logic [127:0] k;
        int           c;
    } exp_t;
    exp_t q[$];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // ---------------- monitor ----------------
    logic [7:0] rtab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    initial begin
        exp_t         cur;
        int           phase;
        logic [127:0] mon_key;
        logic [7:0]   rc;
        phase   = -1;
        mon_key = '0;
        rc      = 8'h00;
        cur.g = 2'b00; cur.k = '0; cur.c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("rst_gnt", 128'(gnt), 128'(0));
                chk("rst_kld", 128'(kld), 128'(0));
                chk("rst_key", key_out, '0);
                chk("rst_vld", 128'(rk_vld), 128'(0));
                chk("rst_idx", 128'(rk_idx), 128'(0));
                chk("rst_done", 128'(done), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
                phase   = -1;
                mon_key = '0;
                rc      = 8'h00;
            end else begin
                if (phase >= 0) begin
                    phase++;
                    if (phase == 12) phase = -1;
                end
                if (kld) begin
                    if (phase != -1) begin
                        n_cmp++; n_err++;
                        $display("FAIL kld_unexpected: kld seen at sequence phase %0d expected none", phase);
                    end else if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL kld_unpredicted: kld at cycle %0d expected no load", cyc);
                    end else begin
                        cur     = q.pop_front();
                        phase   = 0;
                        mon_key = cur.k;
                        chk("kld_cycle", 128'(cyc), 128'(cur.c));
                    end
                end
                if (phase == -1) begin
                    chk("idle_gnt", 128'(gnt), 128'(0));
                    chk("idle_kld", 128'(kld), 128'(0));
                    chk("idle_vld", 128'(rk_vld), 128'(0));
                    chk("idle_done", 128'(done), 128'(0));
                    chk("idle_busy", 128'(busy), 128'(0));
                    chk("idle_idx_range", 128'(rk_idx <= 4'd10), 128'(1));
                    chk("idle_key_hold", key_out, mon_key);
                end else begin
                    chk("seq_gnt", 128'(gnt), 128'(cur.g));
                    chk("seq_key", key_out, cur.k);
                    chk("seq_busy", 128'(busy), 128'(1));
                    chk("seq_kld", 128'(kld), 128'(phase == 0));
                    chk("seq_vld", 128'(rk_vld), 128'(phase >= 1 && phase <= 10));
                    chk("seq_done", 128'(done), 128'((phase == 11) ? cur.g : 2'b00));
                    if (phase <= 10)
                        chk("seq_idx", 128'(rk_idx), 128'(phase));
                    else
                        chk("seq_idx_range", 128'(rk_idx <= 4'd10), 128'(1));
                    if (phase >= 1 && phase <= 10 && rk_idx >= 4'd1 && rk_idx <= 4'd10)
                        chk("rcon_align", 128'(rc), 128'(rtab[int'(rk_idx) - 1]));
                end
                rc = kld ? 8'h01 : xtime(rc);
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    int m_last = 1;
    int m_free = 0;

    function automatic logic [127:0] rkey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input int r, input logic [127:0] k, input int earliest);
        exp_t e;
        e.c = (earliest > m_free) ? earliest : m_free;
        e.g = (r == 1) ? 2'b10 : 2'b01;
        e.k = k;
        q.push_back(e);
        m_free = e.c + 13;
        m_last = r;
    endtask

    task automatic issue(input logic [1:0] r);
        int w;
        req = r;
        if (r == 2'b11) begin
            w = (m_last == 0) ? 1 : 0;
            push(w, w ? key1 : key0, cyc + 1);
            push(1 - w, (1 - w) ? key1 : key0, cyc + 1);
        end else begin
            push(r[1] ? 1 : 0, r[1] ? key1 : key0, cyc + 1);
        end
    endtask

    task automatic wait_dones(input logic [1:0] want, input int bound);
        logic [1:0] pend;
        pend = want;
        for (int i = 0; i < bound && pend != 2'b00; i++) begin
            @(negedge clk);
            if ((done & pend) != 2'b00) begin
                req  = req & ~(done & pend);
                pend = pend & ~done;
            end
        end
        if (pend != 2'b00) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: pending %b after %0d cycles expected 00", pend, bound);
            req = 2'b00;
        end
    endtask

    initial begin
        int         cnt;
        logic [1:0] pat;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Directed single request with the reference key.
        @(negedge clk);
        key0 = 128'h000102030405060708090a0b0c0d0e0f;
        issue(2'b01);
        wait_dones(2'b01, 20);

        // Key changes after grant must not reach key_out.
        @(negedge clk);
        key0 = rkey();
        issue(2'b01);
        repeat (3) @(negedge clk);
        key0 = '1;
        wait_dones(2'b01, 20);

        // Tie, each requester drops after its own done.
        @(negedge clk);
        key0 = rkey(); key1 = rkey();
        issue(2'b11);
        wait_dones(2'b11, 40);

        // Persistent tie over four sequences: strict alternation.
        @(negedge clk);
        key0 = rkey(); key1 = rkey();
        req = 2'b11;
        begin
            int now;
            now = cyc;
            for (int i = 0; i < 4; i++) begin
                int w;
                w = (m_last == 0) ? 1 : 0;
                push(w, w ? key1 : key0, now + 1);
            end
        end
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 4; i++) begin
            @(negedge clk);
            if (done != 2'b00) cnt++;
        end
        req = 2'b00;
        chk("persist_done_count", 128'(cnt), 128'(4));

        // Randomized requests with idle gaps and early drops of single requests.
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            key0 = rkey(); key1 = rkey();
            pat = 2'($urandom_range(1, 3));
            issue(pat);
            if (pat != 2'b11 && $urandom_range(0, 1) == 1) begin
                repeat (4) @(negedge clk);
                req = 2'b00;
            end
            wait_dones(pat, 40);
        end

        // Reset in the middle of expansion aborts without done.
        @(negedge clk);
        key0 = rkey();
        issue(2'b01);
        repeat (6) @(negedge clk);
        chk("pre_abort_idx", 128'(rk_idx), 128'(5));
        rst = 1'b0;
        req = 2'b00;
        #1;
        chk("abort_gnt", 128'(gnt), 128'(0));
        chk("abort_key", key_out, '0);
        chk("abort_vld", 128'(rk_vld), 128'(0));
        chk("abort_idx", 128'(rk_idx), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        m_last = 1;
        m_free = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        key0 = rkey(); key1 = rkey();
        issue(2'b11);
        wait_dones(2'b11, 40);

        repeat (20) @(negedge clk);
        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
